// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write-port arbiter: register index, data word and queued write request.
package regfile_arb_pkg;

   typedef logic [3:0]  reg_idx_t;
   typedef logic [31:0] word_t;

   // R15 is the PC and is written by the fetch logic, never through this port.
   localparam reg_idx_t REG_PC = 4'hF;

   typedef struct packed {
      logic     valid;
      reg_idx_t wa;
      word_t    wd;
   } wr_req_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Circular queue of pending secondary writes with per-entry squash by register index and two parallel match vectors.
// Zero-latency head view; the owner must not push when full or pop when empty.
module regfile_wr_fifo
   import regfile_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  wr_req_t                  push_req,
   input  logic                     pop,
   input  logic                     squash,
   input  logic [3:0]               squash_wa,
   input  logic [3:0]               ra1,
   input  logic [3:0]               ra2,
   output wr_req_t                  head,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DEPTH-1:0]         match1,
   output logic [DEPTH-1:0]         match2
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wr_req_t       mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // Valid bits double as occupancy: cleared on pop, so stale slots never match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (squash && mem[i].valid && (mem[i].wa == squash_wa)) begin
               mem[i].valid <= 1'b0;
            end
         end
         if (pop) begin
            mem[rd_ptr].valid <= 1'b0;
            rd_ptr            <= rd_ptr + PW'(1);
         end
         if (push) begin
            mem[wr_ptr] <= push_req;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      match1 = '0;
      match2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match1[i] = mem[i].valid && (mem[i].wa == ra1);
         match2[i] = mem[i].valid && (mem[i].wa == ra2);
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port: WB wins with zero latency, secondary writes bypass or queue and drain in free cycles.
// Secondary source is held off with sec_ready=!full; stall_req asks the pipeline for WB bubbles on starvation or a full queue.
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_we,
   input  logic [3:0]  wb_wa,
   input  logic [31:0] wb_wd,
   input  logic        sec_valid,
   output logic        sec_ready,
   input  logic [3:0]  sec_wa,
   input  logic [31:0] sec_wd,
   input  logic [3:0]  ra1,
   input  logic [3:0]  ra2,
   output logic        we3,
   output logic [3:0]  wa3,
   output logic [31:0] wd3,
   output logic        hazard1,
   output logic        hazard2,
   output logic        stall_req,
   output logic        sec_drop
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   wr_req_t          head;
   wr_req_t          push_req;
   logic [CW-1:0]    fifo_count;
   logic [DEPTH-1:0] match1;
   logic [DEPTH-1:0] match2;
   logic [SW-1:0]    starve;

   logic empty, full, head_vld, wb_grant, head_wr, accept, bypass, push, pop;

   assign empty    = (fifo_count == '0);
   assign full     = (fifo_count == FULL_CNT);
   assign head_vld = !empty && head.valid;

   // Every grant is gated by reset so a held WB or bypass cannot reach the port mid-reset.
   assign wb_grant = !reset && wb_we && (wb_wa != REG_PC);
   assign head_wr  = !reset && !wb_grant && head_vld;
   assign accept   = !reset && sec_valid && !full;
   assign bypass   = accept && !wb_grant && empty && (sec_wa != REG_PC);
   assign push     = accept && (sec_wa != REG_PC) && !bypass;
   assign pop      = head_wr || (!empty && !head.valid);

   // WB is program-younger, so a same-cycle secondary write to the same register is born dead.
   assign push_req = '{valid: !(wb_grant && (wb_wa == sec_wa)), wa: sec_wa, wd: sec_wd};

   regfile_wr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_req  (push_req),
      .pop       (pop),
      .squash    (wb_grant),
      .squash_wa (wb_wa),
      .ra1       (ra1),
      .ra2       (ra2),
      .head      (head),
      .count     (fifo_count),
      .match1    (match1),
      .match2    (match2)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve <= '0;
      end else if (!head_vld || head_wr) begin
         starve <= '0;
      end else if (starve != STARVE_MAX) begin
         starve <= starve + SW'(1);
      end
   end

   always_comb begin
      we3 = 1'b0;
      wa3 = '0;
      wd3 = '0;
      if (wb_grant) begin
         we3 = 1'b1;
         wa3 = wb_wa;
         wd3 = wb_wd;
      end else if (head_wr) begin
         we3 = 1'b1;
         wa3 = head.wa;
         wd3 = head.wd;
      end else if (bypass) begin
         we3 = 1'b1;
         wa3 = sec_wa;
         wd3 = sec_wd;
      end
   end

   assign sec_ready = !full;
   assign sec_drop  = accept && (sec_wa == REG_PC);
   assign stall_req = !reset && ((starve == STARVE_MAX) || full);
   assign hazard1   = !reset && (ra1 != REG_PC) && ((|match1) || (bypass && (sec_wa == ra1)));
   assign hazard2   = !reset && (ra2 != REG_PC) && ((|match2) || (bypass && (sec_wa == ra2)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random stimulus for regfile_write_arbiter, checked each cycle against a queue-based reference model.
module tb_regfile_write_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_we;
   logic [3:0]  wb_wa;
   logic [31:0] wb_wd;
   logic        sec_valid;
   logic        sec_ready;
   logic [3:0]  sec_wa;
   logic [31:0] sec_wd;
   logic [3:0]  ra1, ra2;
   logic        we3;
   logic [3:0]  wa3;
   logic [31:0] wd3;
   logic        hazard1, hazard2, stall_req, sec_drop;

   regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
      .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_wa(sec_wa), .sec_wd(sec_wd),
      .ra1(ra1), .ra2(ra2),
      .we3(we3), .wa3(wa3), .wd3(wd3),
      .hazard1(hazard1), .hazard2(hazard2), .stall_req(stall_req), .sec_drop(sec_drop)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic [3:0]  wa;
      logic [31:0] wd;
   } ent_t;

   ent_t        q[$];
   int          starve;
   logic [31:0] rf_mdl [16];
   logic [31:0] rf_dut [16];
   bit          last_acc;
   int          n_assert = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_hazard(input logic [3:0] ra, input bit byp);
      if (ra == 4'hF) return 1'b0;
      foreach (q[i]) if (q[i].v && q[i].wa == ra) return 1'b1;
      return byp && (sec_wa == ra);
   endfunction

   // One clock cycle: predict, compare, then advance the model at the rising edge.
   task automatic step(input string tag);
      bit          wbg, full, headv, acc, byp, head_written, drop_head, was_empty, head_dead;
      logic        e_we, e_rdy, e_h1, e_h2, e_stall, e_drop;
      logic [3:0]  e_wa;
      logic [31:0] e_wd;
      wbg = 0; full = 0; headv = 0; acc = 0; byp = 0;
      e_we = 0; e_wa = '0; e_wd = '0; e_rdy = 1; e_h1 = 0; e_h2 = 0; e_stall = 0; e_drop = 0;
      if (!reset) begin
         wbg   = wb_we && (wb_wa != 4'hF);
         full  = (q.size() == DEPTH);
         headv = (q.size() != 0) && q[0].v;
         acc   = sec_valid && !full;
         byp   = acc && !wbg && (q.size() == 0) && (sec_wa != 4'hF);
         if (wbg) begin
            e_we = 1; e_wa = wb_wa; e_wd = wb_wd;
         end else if (headv) begin
            e_we = 1; e_wa = q[0].wa; e_wd = q[0].wd;
         end else if (byp) begin
            e_we = 1; e_wa = sec_wa; e_wd = sec_wd;
         end
         e_rdy   = !full;
         e_drop  = acc && (sec_wa == 4'hF);
         e_h1    = model_hazard(ra1, byp);
         e_h2    = model_hazard(ra2, byp);
         e_stall = (starve == LIMIT) || full;
      end
      #2;
      check({tag, "_we3"}, 64'(we3), 64'(e_we));
      check({tag, "_wa3"}, 64'(wa3), 64'(e_wa));
      check({tag, "_wd3"}, 64'(wd3), 64'(e_wd));
      check({tag, "_ready"}, 64'(sec_ready), 64'(e_rdy));
      check({tag, "_haz1"}, 64'(hazard1), 64'(e_h1));
      check({tag, "_haz2"}, 64'(hazard2), 64'(e_h2));
      check({tag, "_stall"}, 64'(stall_req), 64'(e_stall));
      check({tag, "_drop"}, 64'(sec_drop), 64'(e_drop));
      if (we3 === 1'b1) rf_dut[wa3] = wd3;
      if (e_we) rf_mdl[e_wa] = e_wd;
      last_acc = acc;
      @(posedge clk);
      if (reset) begin
         q.delete();
         starve = 0;
      end else begin
         was_empty    = (q.size() == 0);
         head_dead    = !was_empty && !q[0].v;
         head_written = !wbg && headv;
         drop_head    = head_written || head_dead;
         if (was_empty || head_written || head_dead) starve = 0;
         else if (starve < LIMIT) starve++;
         if (wbg) foreach (q[i]) if (q[i].wa == wb_wa) q[i].v = 1'b0;
         if (drop_head) void'(q.pop_front());
         if (acc && (sec_wa != 4'hF) && !byp)
            q.push_back('{v: !(wbg && (wb_wa == sec_wa)), wa: sec_wa, wd: sec_wd});
      end
      @(negedge clk);
   endtask

   task automatic set_wb(input logic we, input logic [3:0] wa, input logic [31:0] wd);
      wb_we = we; wb_wa = wa; wb_wd = wd;
   endtask

   task automatic set_sec(input logic v, input logic [3:0] wa, input logic [31:0] wd);
      sec_valid = v; sec_wa = wa; sec_wd = wd;
   endtask

   initial begin
      bit pend;
      reset = 1'b1;
      set_wb(0, 4'd0, 32'd0);
      set_sec(0, 4'd0, 32'd0);
      ra1 = 4'd0; ra2 = 4'd0;
      last_acc = 0; starve = 0;
      for (int i = 0; i < 16; i++) begin rf_mdl[i] = '0; rf_dut[i] = '0; end

      // Reset values.
      @(negedge clk); #1;
      check("rst_we3", 64'(we3), 64'd0);
      check("rst_ready", 64'(sec_ready), 64'd1);
      check("rst_stall", 64'(stall_req), 64'd0);
      step("rst");
      step("rst");
      reset = 1'b0;
      step("idle");

      // Bypass into an idle queue.
      set_sec(1, 4'd3, 32'hA5A5_0001);
      #1;
      check("t1_we3", 64'(we3), 64'd1);
      check("t1_wd3", 64'(wd3), 64'hA5A5_0001);
      step("t1");
      set_sec(0, 4'd0, 32'd0);
      #1; check("t1_empty", 64'(sec_ready), 64'd1);
      step("t1b");

      // WB busy: two secondary writes queue, then drain in order.
      set_wb(1, 4'd2, 32'h11);
      set_sec(1, 4'd4, 32'h44);
      step("t2a");
      set_sec(1, 4'd5, 32'h55);
      step("t2b");
      set_sec(0, 4'd0, 32'd0);
      ra1 = 4'd4; ra2 = 4'd15;
      #1;
      check("t2_ready", 64'(sec_ready), 64'd0);
      check("t2_haz1", 64'(hazard1), 64'd1);
      check("t2_stall_full", 64'(stall_req), 64'd1);
      step("t2c");
      set_wb(0, 4'd0, 32'd0); ra1 = 4'd0;
      #1; check("t2_first", 64'({we3, wa3, wd3}), {27'd0, 1'b1, 4'd4, 32'h44});
      step("t2d");
      #1; check("t2_second", 64'({we3, wa3, wd3}), {27'd0, 1'b1, 4'd5, 32'h55});
      step("t2e");

      // Queued R6 squashed by younger WB to R6.
      set_wb(1, 4'd2, 32'h12);
      set_sec(1, 4'd6, 32'h66);
      step("t3a");
      set_sec(0, 4'd0, 32'd0);
      set_wb(1, 4'd6, 32'h77);
      step("t3b");
      set_wb(0, 4'd0, 32'd0);
      #1; check("t3_nowrite", 64'(we3), 64'd0);
      step("t3c");
      step("t3d");
      check("t3_r6", 64'(rf_dut[6]), 64'h77);

      // Starvation: head waits behind continuous WB.
      set_wb(1, 4'd1, 32'h100);
      set_sec(1, 4'd7, 32'h700);
      step("t4e");
      set_sec(0, 4'd0, 32'd0);
      for (int i = 0; i < 7; i++) step("t4w");
      #1; check("t4_stall7", 64'(stall_req), 64'd0);
      step("t4w8");
      #1; check("t4_stall8", 64'(stall_req), 64'd1);
      set_wb(0, 4'd0, 32'd0);
      #1; check("t4_drain", 64'({we3, wa3}), {59'd0, 1'b1, 4'd7});
      step("t4d");
      #1; check("t4_clear", 64'(stall_req), 64'd0);
      step("t4f");

      // R15 from either source never reaches the port.
      set_sec(1, 4'd15, 32'hDEAD);
      #1;
      check("t5_drop", 64'(sec_drop), 64'd1);
      check("t5_we3", 64'(we3), 64'd0);
      step("t5a");
      set_sec(0, 4'd0, 32'd0);
      set_wb(1, 4'd15, 32'hBEEF);
      #1;
      check("t5_wbpc", 64'(we3), 64'd0);
      check("t5_nodrop", 64'(sec_drop), 64'd0);
      step("t5b");

      // Reset with two queued entries discards them.
      set_wb(1, 4'd2, 32'h13);
      set_sec(1, 4'd8, 32'h88);
      step("t6a");
      set_sec(1, 4'd9, 32'h99);
      step("t6b");
      set_sec(0, 4'd0, 32'd0);
      ra1 = 4'd8;
      reset = 1'b1;
      #1;
      check("t6_we3", 64'(we3), 64'd0);
      check("t6_ready", 64'(sec_ready), 64'd1);
      check("t6_haz1", 64'(hazard1), 64'd0);
      step("t6r");
      reset = 1'b0;
      set_wb(0, 4'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         #1; check("t6_post", 64'(we3), 64'd0);
         step("t6p");
      end

      // Random traffic with a holding secondary requester.
      pend = 0;
      for (int c = 0; c < 400; c++) begin
         set_wb(($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)), $urandom);
         if (!pend && ($urandom_range(0, 1) == 1)) begin
            pend   = 1;
            sec_wa = 4'($urandom_range(0, 15));
            sec_wd = $urandom;
         end
         sec_valid = pend;
         ra1 = 4'($urandom_range(0, 15));
         ra2 = 4'($urandom_range(0, 15));
         step($sformatf("rnd%0d", c));
         if (last_acc) pend = 0;
      end
      set_wb(0, 4'd0, 32'd0);
      sec_valid = 0;
      for (int i = 0; i < 4; i++) step("flush");
      for (int i = 0; i < 16; i++) check($sformatf("rf%0d", i), 64'(rf_dut[i]), 64'(rf_mdl[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
